wb2ahb: RTL and testbench
=========================

Name: wb2ahb

Overview:
- Wishbone slave to AHB master bridge; the counterpart of the AHB-to-Wishbone bridge in the same codebase.
- A Wishbone master (CPU or DMA on the Wishbone side) issues single classic read/write cycles.
- The bridge requests the AHB bus, performs one SINGLE/NONSEQ transfer and returns data plus ack to Wishbone.
- One transfer in flight at a time; no bursts, no pipelining across Wishbone cycles.

Parameters:
- AWIDTH, 16, address width on both sides.
- DWIDTH, 32, data width on both sides; hsize is driven as log2(DWIDTH/8) (3'b010 at default).

Ports:
- hclk  input  1  single clock for both sides.
- hresetn  input  1  asynchronous active-low reset.
- adr_i  input  AWIDTH  Wishbone address.
- dat_i  input  DWIDTH  Wishbone write data.
- dat_o  output  DWIDTH  Wishbone read data (registered).
- we_i  input  1  Wishbone write enable.
- cyc_i  input  1  Wishbone valid bus cycle.
- stb_i  input  1  Wishbone strobe.
- ack_o  output  1  Wishbone acknowledge, one-cycle pulse.
- hbusreq  output  1  AHB bus request.
- hgrant  input  1  AHB bus grant.
- haddr  output  AWIDTH  AHB address.
- htrans  output  2  AHB transfer type.
- hwrite  output  1  AHB direction.
- hsize  output  3  AHB size, constant.
- hburst  output  3  AHB burst, constant 3'b000 (SINGLE).
- hwdata  output  DWIDTH  AHB write data.
- hrdata  input  DWIDTH  AHB read data.
- hready  input  1  AHB ready.
- hresp  input  2  AHB response.

Behaviour:
- Reset (async, hresetn=0):
  - state=IDLE, hbusreq=0, htrans=2'b00, haddr=0, hwrite=0, hwdata=0, dat_o=0, ack_o=0.
  - Reset mid-transfer aborts immediately; no ack_o is produced.
- All outputs are registered on posedge hclk.
- FSM states: IDLE, REQ, ADDR, DATA, ACK.
- IDLE:
  - On cyc_i&stb_i: latch adr_i, we_i and dat_i into internal registers, set hbusreq=1, go to REQ.
- REQ:
  - hbusreq=1.
  - When hgrant&hready are sampled high: drive haddr=latched address, hwrite=latched we, htrans=2'b10 (NONSEQ), go to ADDR.
- ADDR:
  - Hold address and control until hready=1.
  - On hready: htrans=2'b00, hwdata=latched data, hbusreq=0, go to DATA.
- DATA, waiting for hready:
  - hready=1 and hresp=OKAY (00): capture hrdata into dat_o if read (dat_o unchanged on write), go to ACK.
  - hresp=ERROR (01): see the Optional Feature section.
  - hresp=RETRY (10) or SPLIT (11):
    - On the first response cycle (hready=0): set hbusreq=1.
    - On the second cycle (hready=1): go to REQ and re-issue the same transfer. Retries are unlimited.
- ACK:
  - ack_o=1 for exactly one cycle, then go to IDLE.
  - A new request is not accepted in ACK, so the minimum gap between ack_o pulses is 1 idle cycle.
- Latency: with hgrant already high and zero-wait slaves, the request is seen at edge 0 and ack_o is high after edge 4 (4 cycles).
- cyc_i dropped mid-transfer:
  - The AHB transfer still completes; AHB protocol is never violated.
  - The result is discarded and ack_o is suppressed.
  - The bridge returns to IDLE.
- hgrant lost while in REQ: wait; hbusreq stays asserted.
- htrans=BUSY and SEQ are never driven.
- hburst and hsize are constant.

Optional Feature:
- Macro: WB2AHB_ERR_EN.
- Defined:
  - Adds port err_o (output, 1 bit), reset value 0.
  - AHB ERROR in DATA (second response cycle) produces err_o=1 for one cycle instead of ack_o; dat_o is unchanged.
  - ack_o and err_o are never high together.
- Undefined:
  - No err_o port.
  - ERROR is treated as completion: ack_o pulses and, for a read, dat_o is loaded with 0.

Test Plan:
- Write, zero wait: hgrant=1, hready=1, Wishbone write adr=16'h0040 dat=32'hDEADBEEF.
  - -> haddr=0040, hwrite=1, htrans=10 for one cycle; hwdata=DEADBEEF in the next cycle; ack_o after 4 cycles.
- Read, 3 wait states: slave returns hrdata=32'h12345678 after 3 hready=0 cycles.
  - -> dat_o=12345678 coincident with ack_o; latency 7 cycles.
- Grant delayed: hgrant low for 5 cycles.
  - -> hbusreq held, htrans=00 throughout, NONSEQ is issued in the cycle after grant.
- RETRY: slave gives RETRY once.
  - -> transfer re-issued with identical haddr/hwrite/hwdata; exactly one ack_o.
- ERROR, with WB2AHB_ERR_EN defined:
  - -> err_o pulse, no ack_o, dat_o unchanged.
- ERROR, with WB2AHB_ERR_EN undefined:
  - -> ack_o pulse, dat_o=0.
- Reset mid-operation:
  - hresetn=0 asserted in DATA -> outputs at reset values without a clock edge, no ack_o.
  - Next request after reset release completes normally.

Source files
------------

// File: rtl/wb2ahb_if.sv
// -----------------------------------------------------------------------------
// wb2ahb_if : bus bundle between a Wishbone master, the wb2ahb bridge and an
//             AHB slave/arbiter.
//
// Signals keep the bridge's port names so waveforms line up with the bridge:
//   Wishbone : adr_i, dat_i, dat_o, we_i, cyc_i, stb_i, ack_o (+ err_o)
//   AHB      : hbusreq, hgrant, haddr, htrans, hwrite, hsize, hburst,
//              hwdata, hrdata, hready, hresp
//
// Modports:
//   slave  - the bridge view (Wishbone slave that is also the AHB master)
//   master - the environment view (Wishbone master plus AHB slave/arbiter)
//
// Build option: WB2AHB_ERR_EN adds the err_o signal.
// -----------------------------------------------------------------------------
interface wb2ahb_if #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 32
);
   // Wishbone side
   logic [AWIDTH-1:0] adr_i;
   logic [DWIDTH-1:0] dat_i;
   logic [DWIDTH-1:0] dat_o;
   logic              we_i;
   logic              cyc_i;
   logic              stb_i;
   logic              ack_o;
`ifdef WB2AHB_ERR_EN
   logic              err_o;
`endif

   // AHB side
   logic              hbusreq;
   logic              hgrant;
   logic [AWIDTH-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [DWIDTH-1:0] hwdata;
   logic [DWIDTH-1:0] hrdata;
   logic              hready;
   logic [1:0]        hresp;

   modport slave (
      input  adr_i, dat_i, we_i, cyc_i, stb_i,
      input  hgrant, hrdata, hready, hresp,
      output dat_o, ack_o,
      output hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata
`ifdef WB2AHB_ERR_EN
      , output err_o
`endif
   );

   modport master (
      output adr_i, dat_i, we_i, cyc_i, stb_i,
      output hgrant, hrdata, hready, hresp,
      input  dat_o, ack_o,
      input  hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata
`ifdef WB2AHB_ERR_EN
      , input err_o
`endif
   );

endinterface

// File: rtl/wb2ahb.sv
// -----------------------------------------------------------------------------
// wb2ahb : Wishbone classic slave to AHB master bridge.
//
// A Wishbone single read/write cycle is turned into one AHB SINGLE/NONSEQ
// transfer. Only one transfer is in flight; the Wishbone cycle is answered
// with a one-cycle ack_o once the AHB data phase has finished.
//
// Ports:
//   hclk     - single clock for both buses
//   hresetn  - asynchronous active-low reset
//   bus      - wb2ahb_if.slave: Wishbone slave signals (adr_i, dat_i, dat_o,
//              we_i, cyc_i, stb_i, ack_o[, err_o]) and AHB master signals
//              (hbusreq, hgrant, haddr, htrans, hwrite, hsize, hburst,
//              hwdata, hrdata, hready, hresp)
//
// Parameters:
//   AWIDTH   - address width on both sides
//   DWIDTH   - data width on both sides; hsize = log2(DWIDTH/8)
//
// Build option:
//   WB2AHB_ERR_EN - an AHB ERROR response is reported on err_o instead of
//                   ack_o. Without it, ERROR completes the cycle with ack_o
//                   and a read returns zero.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module wb2ahb #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 32
) (
   input  logic     hclk,
   input  logic     hresetn,
   wb2ahb_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ADDR,
      DATA,
      ACK
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [1:0] HRESP_RETRY   = 2'b10;
   localparam logic [1:0] HRESP_SPLIT   = 2'b11;
   localparam logic [2:0] HSIZE         = 3'($clog2(DWIDTH / 8));
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   state_e              state_q,   state_d;
   logic [AWIDTH-1:0]   adr_q,     adr_d;     // latched Wishbone request
   logic                we_q,      we_d;
   logic [DWIDTH-1:0]   wdat_q,    wdat_d;
   logic                drop_q,    drop_d;    // cyc_i went away: discard result
   logic                hbusreq_q, hbusreq_d;
   logic [AWIDTH-1:0]   haddr_q,   haddr_d;
   logic [1:0]          htrans_q,  htrans_d;
   logic                hwrite_q,  hwrite_d;
   logic [DWIDTH-1:0]   hwdata_q,  hwdata_d;
   logic [DWIDTH-1:0]   dat_q,     dat_d;
   logic                ack_q,     ack_d;
   logic                resp_busy;            // a response pulse is on the bus now
`ifdef WB2AHB_ERR_EN
   logic                berr_q,    berr_d;    // data phase ended with ERROR
   logic                err_q,     err_d;
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= IDLE;
         adr_q     <= '0;
         we_q      <= 1'b0;
         wdat_q    <= '0;
         drop_q    <= 1'b0;
         hbusreq_q <= 1'b0;
         haddr_q   <= '0;
         htrans_q  <= HTRANS_IDLE;
         hwrite_q  <= 1'b0;
         hwdata_q  <= '0;
         dat_q     <= '0;
         ack_q     <= 1'b0;
`ifdef WB2AHB_ERR_EN
         berr_q    <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         we_q      <= we_d;
         wdat_q    <= wdat_d;
         drop_q    <= drop_d;
         hbusreq_q <= hbusreq_d;
         haddr_q   <= haddr_d;
         htrans_q  <= htrans_d;
         hwrite_q  <= hwrite_d;
         hwdata_q  <= hwdata_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
`ifdef WB2AHB_ERR_EN
         berr_q    <= berr_d;
         err_q     <= err_d;
`endif
      end
   end

   // The master samples ack_o at the same edge at which the bridge is back in
   // IDLE, and stb_i is still high at that edge. Ignoring the request while the
   // response pulse is on the bus keeps that edge from starting a second,
   // duplicate transfer.
`ifdef WB2AHB_ERR_EN
   assign resp_busy = ack_q | err_q;
`else
   assign resp_busy = ack_q;
`endif

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      we_d      = we_q;
      wdat_d    = wdat_q;
      drop_d    = drop_q;
      hbusreq_d = hbusreq_q;
      haddr_d   = haddr_q;
      htrans_d  = htrans_q;
      hwrite_d  = hwrite_q;
      hwdata_d  = hwdata_q;
      dat_d     = dat_q;
      ack_d     = 1'b0;
`ifdef WB2AHB_ERR_EN
      berr_d    = berr_q;
      err_d     = 1'b0;
`endif

      // Once cyc_i drops during a transfer the AHB side still runs to the end,
      // but nothing is handed back to Wishbone.
      if (state_q != IDLE && !bus.cyc_i) begin
         drop_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.cyc_i && bus.stb_i && !resp_busy) begin
               adr_d     = bus.adr_i;
               we_d      = bus.we_i;
               wdat_d    = bus.dat_i;
               drop_d    = 1'b0;
               hbusreq_d = 1'b1;
`ifdef WB2AHB_ERR_EN
               berr_d    = 1'b0;
`endif
               state_d   = REQ;
            end
         end

         REQ: begin
            // Bus ownership changes only on a ready edge, so both must be high.
            hbusreq_d = 1'b1;
            if (bus.hgrant && bus.hready) begin
               haddr_d  = adr_q;
               hwrite_d = we_q;
               htrans_d = HTRANS_NONSEQ;
               state_d  = ADDR;
            end
         end

         ADDR: begin
            if (bus.hready) begin
               htrans_d  = HTRANS_IDLE;
               hwdata_d  = wdat_q;
               hbusreq_d = 1'b0;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (bus.hresp == HRESP_RETRY || bus.hresp == HRESP_SPLIT) begin
               // First response cycle: ask for the bus again right away.
               // Second cycle: go back and replay the same transfer; address,
               // direction and write data are still in the latches.
               hbusreq_d = 1'b1;
               if (bus.hready) begin
                  state_d = REQ;
               end
            end else if (bus.hready) begin
               state_d = ACK;
               if (bus.hresp == HRESP_ERROR) begin
`ifdef WB2AHB_ERR_EN
                  berr_d = 1'b1;
`else
                  if (!we_q && !drop_d) begin
                     dat_d = '0;
                  end
`endif
               end else if (!we_q && !drop_d) begin
                  dat_d = bus.hrdata;
               end
            end
         end

         ACK: begin
            state_d = IDLE;
            if (!drop_d) begin
`ifdef WB2AHB_ERR_EN
               if (berr_q) begin
                  err_d = 1'b1;
               end else begin
                  ack_d = 1'b1;
               end
`else
               ack_d = 1'b1;
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.dat_o   = dat_q;
   assign bus.ack_o   = ack_q;
`ifdef WB2AHB_ERR_EN
   assign bus.err_o   = err_q;
`endif
   assign bus.hbusreq = hbusreq_q;
   assign bus.haddr   = haddr_q;
   assign bus.htrans  = htrans_q;
   assign bus.hwrite  = hwrite_q;
   assign bus.hwdata  = hwdata_q;
   assign bus.hsize   = HSIZE;
   assign bus.hburst  = HBURST_SINGLE;

endmodule

// File: tb/tb_wb2ahb.sv
// -----------------------------------------------------------------------------
// tb_wb2ahb : self-checking bench for wb2ahb.
//
// A driver issues Wishbone cycles and pushes the expected response into a
// scoreboard queue; a monitor pops and compares whenever ack_o/err_o shows up.
// An AHB slave model with its own memory answers the transfers with scripted
// wait states and responses; a separate reference memory predicts read data.
// -----------------------------------------------------------------------------
module tb_wb2ahb;
   localparam int AW = 16;
   localparam int DW = 32;

   typedef struct {
      bit          err;
      logic [31:0] dat;
   } exp_t;

   logic hclk = 1'b0;
   logic hresetn = 1'b1;
   always #5 hclk = ~hclk;

   wb2ahb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   wb2ahb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   logic errw;
`ifdef WB2AHB_ERR_EN
   assign errw = bus.err_o;
`else
   assign errw = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int ack_cnt = 0;
   exp_t sb[$];

   // current transaction, shared with the AHB slave model
   logic [15:0] cur_adr;
   bit          cur_we;
   logic [31:0] cur_dat;
   int          cur_wait;
   int          cur_resp;     // 0 OKAY, 1 ERROR, 2 RETRY once, 3 SPLIT once
   int          retry_left;
   int          s_attempts;

   logic [31:0] ref_mem[logic [15:0]];
   logic [31:0] slv_mem[logic [15:0]];
   logic [31:0] ref_dato;

   function automatic logic [31:0] dflt(input logic [15:0] a);
      return {a, ~a};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // AHB slave model
   // ---------------------------------------------------------------------------
   int sph;
   int scnt;
   logic [15:0] s_adr;
   bit s_we;
   initial begin
      bus.hready = 1'b1;
      bus.hresp  = 2'b00;
      bus.hrdata = '0;
      sph = 0;
      scnt = 0;
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            sph = 0;
            bus.hready = 1'b1;
            bus.hresp  = 2'b00;
         end else begin
            case (sph)
               0: begin
                  bus.hready = 1'b1;
                  bus.hresp  = 2'b00;
                  if (bus.htrans == 2'b10) begin
                     s_attempts++;
                     chk("haddr", 32'(bus.haddr), 32'(cur_adr));
                     chk("hwrite", 32'(bus.hwrite), 32'(cur_we));
                     s_adr = bus.haddr;
                     s_we  = bus.hwrite;
                     scnt  = cur_wait;
                     sph   = 1;
                  end
               end
               1: begin
                  if (scnt == cur_wait) begin
                     chk("nonseq_one_cycle", 32'(bus.htrans), 32'd0);
                     if (s_we) chk("hwdata", bus.hwdata, cur_dat);
                  end
                  if (scnt > 0) begin
                     bus.hready = 1'b0;
                     scnt--;
                  end else if (retry_left > 0) begin
                     bus.hready = 1'b0;
                     bus.hresp  = (cur_resp == 3) ? 2'b11 : 2'b10;
                     retry_left--;
                     sph = 2;
                  end else if (cur_resp == 1) begin
                     bus.hready = 1'b0;
                     bus.hresp  = 2'b01;
                     bus.hrdata = $urandom;
                     sph = 2;
                  end else begin
                     bus.hready = 1'b1;
                     bus.hresp  = 2'b00;
                     if (s_we) slv_mem[s_adr] = bus.hwdata;
                     else bus.hrdata = slv_mem.exists(s_adr) ? slv_mem[s_adr] : dflt(s_adr);
                     sph = 0;
                  end
               end
               default: begin
                  // second cycle of a two-cycle response, hresp held
                  bus.hready = 1'b1;
                  sph = 0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge hclk);
         if (bus.ack_o || errw) begin
            ack_cnt++;
            chk("ack_err_exclusive", 32'(bus.ack_o & errw), 32'd0);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing outstanding at %0t",
                        bus.ack_o, errw, $time);
            end else begin
               e = sb.pop_front();
               chk("resp_is_err", 32'(errw), 32'(e.err));
               chk("dat_o", bus.dat_o, e.dat);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic wb_txn(input bit we, input logic [15:0] a, input logic [31:0] d,
                         input int w, input int resp, input int g);
      exp_t e;
      int   n;
      int   lat;
      bit   done;
      cur_adr = a; cur_we = we; cur_dat = d; cur_wait = w; cur_resp = resp;
      retry_left = (resp >= 2) ? 1 : 0;
      s_attempts = 0;
      // reference model
      if (resp == 1) begin
`ifdef WB2AHB_ERR_EN
         e.err = 1'b1;
`else
         e.err = 1'b0;
         if (!we) ref_dato = '0;
`endif
      end else begin
         e.err = 1'b0;
         if (we) ref_mem[a] = d;
         else ref_dato = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      end
      e.dat = ref_dato;
      sb.push_back(e);
      lat = 3 + ((g > 1) ? g : 1) + w + ((resp == 1) ? 1 : ((resp >= 2) ? 4 + w : 0));

      @(negedge hclk);
      if (g > 0) bus.hgrant = 1'b0;
      bus.adr_i = a; bus.dat_i = d; bus.we_i = we;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(negedge hclk);
         n++;
         if (g > 0 && n <= g) begin
            chk("nogrant_hbusreq", 32'(bus.hbusreq), 32'd1);
            chk("nogrant_htrans", 32'(bus.htrans), 32'd0);
            if (n == g) bus.hgrant = 1'b1;
         end
         done = bus.ack_o | errw;
      end
      chk("timeout", 32'(done), 32'd1);
      chk("latency", 32'(n - 1), 32'(lat));
      chk("attempts", 32'(s_attempts), (resp >= 2) ? 32'd2 : 32'd1);
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
   endtask

   initial begin
      int n0;
      bit rwe;
      logic [15:0] ra;
      int rr;
      int rsp;
      bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.hgrant = 1'b1;
      ref_dato = '0;
      cur_adr = '0; cur_we = 1'b0; cur_dat = '0; cur_wait = 0; cur_resp = 0;
      retry_left = 0; s_attempts = 0;

      #1 hresetn = 1'b0;
      #2;
      chk("rst_hbusreq", 32'(bus.hbusreq), 32'd0);
      chk("rst_htrans", 32'(bus.htrans), 32'd0);
      chk("rst_haddr", 32'(bus.haddr), 32'd0);
      chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
      chk("rst_hwdata", bus.hwdata, 32'd0);
      chk("rst_dat_o", bus.dat_o, 32'd0);
      chk("rst_ack", 32'(bus.ack_o), 32'd0);
      chk("rst_err", 32'(errw), 32'd0);
      chk("hsize", 32'(bus.hsize), 32'd2);
      chk("hburst", 32'(bus.hburst), 32'd0);
      @(negedge hclk);
      hresetn = 1'b1;

      // directed cases
      wb_txn(1'b1, 16'h0040, 32'hDEADBEEF, 0, 0, 0);   // write, zero wait: 4 cycles
      wb_txn(1'b1, 16'h0080, 32'h12345678, 0, 0, 0);
      wb_txn(1'b0, 16'h0080, 32'h0, 3, 0, 0);          // read, 3 waits: 7 cycles
      wb_txn(1'b0, 16'h0040, 32'h0, 0, 0, 5);          // grant delayed 5 cycles
      wb_txn(1'b1, 16'h00C0, 32'hA5A50001, 1, 2, 0);   // RETRY once
      wb_txn(1'b0, 16'h00C0, 32'h0, 0, 3, 0);          // SPLIT once, read back
      wb_txn(1'b0, 16'h0040, 32'h0, 0, 1, 0);          // ERROR read
      wb_txn(1'b1, 16'h0044, 32'h00001111, 0, 1, 0);   // ERROR write

      // cyc_i dropped mid-transfer: AHB completes, no ack, dat_o untouched
      cur_adr = 16'h0080; cur_we = 1'b0; cur_dat = '0; cur_wait = 2; cur_resp = 0;
      retry_left = 0; s_attempts = 0;
      n0 = ack_cnt;
      @(negedge hclk);
      bus.adr_i = 16'h0080; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
      repeat (2) @(negedge hclk);
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      repeat (12) @(negedge hclk);
      chk("drop_no_ack", 32'(ack_cnt), 32'(n0));
      chk("drop_dat_o", bus.dat_o, ref_dato);
      chk("drop_ahb_done", 32'(s_attempts), 32'd1);
      chk("drop_hbusreq", 32'(bus.hbusreq), 32'd0);

      // reset while in the data phase
      cur_adr = 16'h0040; cur_we = 1'b1; cur_dat = 32'hCAFEF00D; cur_wait = 6; cur_resp = 0;
      retry_left = 0; s_attempts = 0;
      n0 = ack_cnt;
      @(negedge hclk);
      bus.adr_i = 16'h0040; bus.dat_i = 32'hCAFEF00D; bus.we_i = 1'b1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
      repeat (4) @(negedge hclk);
      #2 hresetn = 1'b0;
      #1;
      chk("midrst_ack", 32'(bus.ack_o), 32'd0);
      chk("midrst_hbusreq", 32'(bus.hbusreq), 32'd0);
      chk("midrst_htrans", 32'(bus.htrans), 32'd0);
      chk("midrst_haddr", 32'(bus.haddr), 32'd0);
      chk("midrst_hwrite", 32'(bus.hwrite), 32'd0);
      chk("midrst_hwdata", bus.hwdata, 32'd0);
      chk("midrst_dat_o", bus.dat_o, 32'd0);
      ref_dato = '0;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      repeat (3) @(negedge hclk);
      #2 hresetn = 1'b1;
      chk("midrst_no_ack", 32'(ack_cnt), 32'(n0));

      wb_txn(1'b0, 16'h0040, 32'h0, 1, 0, 0);          // normal after reset

      // randomized traffic over a small address window
      for (int i = 0; i < 40; i++) begin
         rwe = 1'($urandom_range(0, 1));
         ra  = 16'h0100 + 16'($urandom_range(0, 7)) * 16'd4;
         rr  = $urandom_range(0, 9);
         rsp = (rr < 6) ? 0 : (rr == 6) ? 1 : (rr == 7) ? 2 : 3;
         wb_txn(rwe, ra, $urandom, $urandom_range(0, 3), rsp, $urandom_range(0, 3));
      end

      repeat (10) @(negedge hclk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
